// File: rtl/oled_spi_sink_pkg.sv
// Shared constants for the OLED SPI display model: decoded command codes and
// the address-decoder state encoding.
package oled_spi_sink_pkg;

   localparam logic [7:0] CMD_SET_COL  = 8'h21;
   localparam logic [7:0] CMD_SET_PAGE = 8'h22;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COL_S,
      ST_COL_E,
      ST_PG_S,
      ST_PG_E
   } dec_state_t;

endpackage

// File: rtl/oled_spi_sink_if.sv
// OLED 4-wire SPI pin bundle (plus display reset) between display master and sink.
interface oled_spi_sink_if;
   logic cs_n;
   logic sclk;
   logic dc;
   logic sdin;
   logic oled_rst;

   modport master (output cs_n, output sclk, output dc, output sdin, output oled_rst);
   modport slave  (input  cs_n, input  sclk, input  dc, input  sdin, input  oled_rst);
endinterface

// File: rtl/oled_spi_sink_byte_rx.sv
// Oversampling SPI byte assembler: synchronises the pins, detects sclk rising
// edges and shifts MSB-first bytes tagged with dc.
module oled_spi_byte_rx #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   oled_spi_sink_if.slave      spi,
   output logic                o_rx_valid,
   output logic [7:0]          o_rx_byte,
   output logic                o_rx_dc,
   output logic                o_frame_err,
   output logic                o_dev_rst
);

   logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_rst_sync, r_dc_sync, r_sdin_sync;
   logic                   r_sclk_prev, r_cs_prev;
   logic [6:0]             r_shift;
   logic [2:0]             r_bit_cnt;
   logic                   r_rx_valid, r_rx_dc, r_frame_err;
   logic [7:0]             r_rx_byte;

   logic w_cs, w_sclk, w_dc, w_sdin, w_sclk_rise, w_capture;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= '1;
         r_rst_sync  <= '1;
         r_dc_sync   <= '0;
         r_sdin_sync <= '0;
         r_sclk_prev <= 1'b1;
         r_cs_prev   <= 1'b1;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi.cs_n};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0],  spi.oled_rst};
         r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   spi.dc};
         r_sdin_sync <= {r_sdin_sync[SYNC_STAGES-2:0], spi.sdin};
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_dc        = r_dc_sync[SYNC_STAGES-1];
   assign w_sdin      = r_sdin_sync[SYNC_STAGES-1];
   assign o_dev_rst   = ~r_rst_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_prev;
   // cs_n seen low last cycle still qualifies an edge, so a byte whose 8th edge
   // coincides with cs_n rising is delivered rather than dropped.
   assign w_capture   = w_sclk_rise & ~(w_cs & r_cs_prev);

   always_ff @(posedge clk) begin
      if (!rst_n || o_dev_rst) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_byte   <= '0;
         r_rx_dc     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_capture) begin
            r_shift <= {r_shift[5:0], w_sdin};
            if (r_bit_cnt == 3'd7) begin
               r_rx_valid <= 1'b1;
               r_rx_byte  <= {r_shift, w_sdin};
               r_rx_dc    <= w_dc;
               r_bit_cnt  <= '0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
         end else if (w_cs) begin
            r_bit_cnt   <= '0;
            r_frame_err <= (r_bit_cnt != '0);
         end
      end
   end

   assign o_rx_valid  = r_rx_valid;
   assign o_rx_byte   = r_rx_byte;
   assign o_rx_dc     = r_rx_dc;
   assign o_frame_err = r_frame_err;

endmodule

// File: rtl/oled_spi_sink.sv
// SSD1306-style display model: decodes column/page address commands and turns
// data bytes into GDDRAM write strobes with horizontal auto-increment.
module oled_spi_sink
   import oled_spi_sink_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COL_W       = 7,
   parameter int unsigned PAGE_W      = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   oled_spi_sink_if.slave          spi,
   output logic                    rx_valid,
   output logic [7:0]              rx_byte,
   output logic                    rx_dc,
   output logic                    cmd_valid,
   output logic [7:0]              cmd_byte,
   output logic                    ram_we,
   output logic [PAGE_W+COL_W-1:0] ram_addr,
   output logic [7:0]              ram_wdata,
   output logic                    frame_err,
   output logic                    proto_err
);

   logic       w_rx_valid, w_rx_dc, w_dev_rst;
   logic [7:0] w_rx_byte;

   oled_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi         (spi),
      .o_rx_valid  (w_rx_valid),
      .o_rx_byte   (w_rx_byte),
      .o_rx_dc     (w_rx_dc),
      .o_frame_err (frame_err),
      .o_dev_rst   (w_dev_rst)
   );

   dec_state_t r_state, w_state_nxt;
   logic w_cmd_valid, w_data, w_proto, w_set_cs, w_set_ce, w_set_ps, w_set_pe;

   logic [COL_W-1:0]  r_col, r_col_start, r_col_end, r_pend;
   logic [PAGE_W-1:0] r_page, r_page_start, r_page_end;
   logic              r_ram_we, r_proto_err;
   logic [7:0]        r_ram_wdata, r_cmd_byte;
   logic [PAGE_W+COL_W-1:0] r_ram_addr;

   always_ff @(posedge clk) begin
      if (!rst_n || w_dev_rst) r_state <= ST_IDLE;
      else                     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_rx_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (!w_rx_dc && w_rx_byte == CMD_SET_COL)       w_state_nxt = ST_COL_S;
               else if (!w_rx_dc && w_rx_byte == CMD_SET_PAGE) w_state_nxt = ST_PG_S;
            end
            ST_COL_S: w_state_nxt = w_rx_dc ? ST_IDLE : ST_COL_E;
            ST_PG_S:  w_state_nxt = w_rx_dc ? ST_IDLE : ST_PG_E;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_cmd_valid = 1'b0;
      w_data      = 1'b0;
      w_proto     = 1'b0;
      w_set_cs    = 1'b0;
      w_set_ce    = 1'b0;
      w_set_ps    = 1'b0;
      w_set_pe    = 1'b0;
      if (w_rx_valid) begin
         if (w_rx_dc) begin
            w_data  = 1'b1;
            w_proto = (r_state != ST_IDLE);
         end else begin
            case (r_state)
               ST_IDLE:  w_cmd_valid = (w_rx_byte != CMD_SET_COL) && (w_rx_byte != CMD_SET_PAGE);
               ST_COL_S: w_set_cs = 1'b1;
               ST_COL_E: w_set_ce = 1'b1;
               ST_PG_S:  w_set_ps = 1'b1;
               ST_PG_E:  w_set_pe = 1'b1;
               default:  ;
            endcase
         end
      end
   end

   // The start argument is held in r_pend and committed together with the end
   // argument, so a range update abandoned by a data byte leaves no trace.
   always_ff @(posedge clk) begin
      if (!rst_n || w_dev_rst) begin
         r_col        <= '0;
         r_col_start  <= '0;
         r_col_end    <= '1;
         r_page       <= '0;
         r_page_start <= '0;
         r_page_end   <= '1;
         r_pend       <= '0;
         r_ram_we     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_wdata  <= '0;
         r_proto_err  <= 1'b0;
         r_cmd_byte   <= '0;
      end else begin
         r_ram_we    <= w_data;
         r_proto_err <= w_proto;
         if (w_cmd_valid) r_cmd_byte <= w_rx_byte;
         if (w_set_cs || w_set_ps) r_pend <= w_rx_byte[COL_W-1:0];
         if (w_set_ce) begin
            r_col_start <= r_pend;
            r_col_end   <= w_rx_byte[COL_W-1:0];
            r_col       <= r_pend;
         end
         if (w_set_pe) begin
            r_page_start <= r_pend[PAGE_W-1:0];
            r_page_end   <= w_rx_byte[PAGE_W-1:0];
            r_page       <= r_pend[PAGE_W-1:0];
         end
         if (w_data) begin
            r_ram_addr  <= {r_page, r_col};
            r_ram_wdata <= w_rx_byte;
            if (r_col == r_col_end) begin
               r_col  <= r_col_start;
               r_page <= (r_page == r_page_end) ? r_page_start : r_page + PAGE_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end
      end
   end

   assign rx_valid  = w_rx_valid;
   assign rx_byte   = w_rx_byte;
   assign rx_dc     = w_rx_dc;
   assign cmd_valid = w_cmd_valid;
   assign cmd_byte  = w_cmd_valid ? w_rx_byte : r_cmd_byte;
   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign proto_err = r_proto_err;

endmodule
